// File: rtl/cnn_params.sv
// Shared parameters and helpers for the CNN datapath. The window element index
// convention here is also used by the weight packer and the MAC stage.
package cnn_params;

    // Bits needed to count 0..value-1. Never returns less than 1, so a
    // degenerate size still gets a legal one-bit counter.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            width++;
        end
        if (width < 1) begin
            width = 1;
        end
        return width;
    endfunction

    // Flattened window element index. r=0 is the oldest (top) row and c=0 is
    // the oldest (leftmost) column.
    function automatic int win_idx(input int r, input int c, input int kernel);
        return r * kernel + c;
    endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of delay: an enable-advanced circular buffer with a column
// pointer. o_dout always holds the entry that the next accepted pixel will
// overwrite, i.e. the pixel exactly DEPTH accepted pixels older.
module line_buffer
    import cnn_params::*;
#(
    parameter int DEPTH = 28,
    parameter int N     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [N-1:0] i_din,
    output logic [N-1:0] o_dout
);

    localparam int PTR_W = clog2(DEPTH);

    logic [N-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_next;
    logic [N-1:0]     r_dout;

    assign w_ptr_next = (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);

    // Storage write; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_din;
        end
    end

    // Column pointer tracks the write slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= w_ptr_next;
        end
    end

    // Registered read prefetches the next slot, so the oldest pixel is ready
    // combinationally when the next pixel arrives. The slot being read is not
    // written until the following enable, so no read/write collision occurs.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_dout <= r_mem[w_ptr_next];
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KERNEL x KERNEL sliding-window generator (stride 1, no padding).
// Takes raster-order pixels, keeps KERNEL-1 rows in line buffers and presents
// a flattened window with a one-cycle enable, one cycle after each pixel.
module conv_window_gen
    import cnn_params::*;
#(
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               pix_in,
    input  logic                       pix_valid,
    output logic [KERNEL*KERNEL*N-1:0] data2conv,
    output logic                       en_out,
    output logic                       frame_done
);

    localparam int COL_W = clog2(IMG_W);
    localparam int ROW_W = clog2(IMG_H);

    logic [COL_W-1:0]           r_col;
    logic [ROW_W-1:0]           r_row;
    logic                       w_col_last;
    logic                       w_row_last;
    logic                       w_win_ok;
    logic [KERNEL-1:0][N-1:0]   w_tap;
    logic [N-1:0]               r_win [KERNEL][KERNEL];
    logic                       r_en;
    logic                       r_frame_done;

    assign w_col_last = (r_col == COL_W'(IMG_W - 1));
    assign w_row_last = (r_row == ROW_W'(IMG_H - 1));

    // A window is complete once KERNEL-1 full rows and columns precede the
    // current pixel; with a 1x1 kernel every pixel is a window.
    generate
        if (KERNEL == 1) begin : g_ok_k1
            assign w_win_ok = 1'b1;
        end else begin : g_ok_kn
            assign w_win_ok = (r_row >= ROW_W'(KERNEL - 1)) &&
                              (r_col >= COL_W'(KERNEL - 1));
        end
    endgenerate

    // Raster position of the pixel being accepted this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (pix_valid) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Tap k is the pixel k rows above the incoming one, same column.
    assign w_tap[0] = pix_in;
    generate
        for (genvar gi = 1; gi < KERNEL; gi++) begin : g_line
            line_buffer #(
                .DEPTH (IMG_W),
                .N     (N)
            ) u_line (
                .clk    (clk),
                .rst    (rst),
                .i_en   (pix_valid),
                .i_din  (w_tap[gi-1]),
                .o_dout (w_tap[gi])
            );
        end
    endgenerate

    // Window shift: every row moves one column toward c=0 and the newest
    // column is filled from the taps, newest row at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (pix_valid) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][KERNEL-1] <= w_tap[KERNEL-1-r];
            end
        end
    end

    // Output flags, aligned with the window that the accepted pixel completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en         <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_en         <= pix_valid && w_win_ok;
            r_frame_done <= pix_valid && w_col_last && w_row_last;
        end
    end

    // Flatten the window into the MAC stage's packing.
    generate
        for (genvar gi = 0; gi < KERNEL; gi++) begin : g_row
            for (genvar gj = 0; gj < KERNEL; gj++) begin : g_col
                assign data2conv[win_idx(gi, gj, KERNEL)*N +: N] = r_win[gi][gj];
            end
        end
    endgenerate

    assign en_out     = r_en;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a 3x3 instance on a 5x5 image and a 1x1 instance
// on a 4x4 image, compared against a frame-array reference model.
module tb_conv_window_gen;

    localparam int K  = 3;
    localparam int N  = 4;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int W1 = 4;
    localparam int H1 = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       pix_in;
    logic               pix_valid;
    logic [K*K*N-1:0]   data2conv;
    logic               en_out;
    logic               frame_done;

    logic [N-1:0]       pix_in_k1;
    logic               pix_valid_k1;
    logic [N-1:0]       data2conv_k1;
    logic               en_out_k1;
    logic               frame_done_k1;

    int checks   = 0;
    int failures = 0;

    // Reference model state: the current frame as a plain 2-D array plus the
    // raster position of the next pixel.
    int img [H][W];
    int m_row, m_col, win_cnt;
    int m1_idx, m1_cnt;
    logic [N-1:0] m1_last;

    conv_window_gen #(.KERNEL(K), .N(N), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .data2conv  (data2conv),
        .en_out     (en_out),
        .frame_done (frame_done)
    );

    conv_window_gen #(.KERNEL(1), .N(N), .IMG_W(W1), .IMG_H(H1)) dut_k1 (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in_k1),
        .pix_valid  (pix_valid_k1),
        .data2conv  (data2conv_k1),
        .en_out     (en_out_k1),
        .frame_done (frame_done_k1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on the 3x3 instance; outputs are checked 1 time unit after the
    // edge, where they describe the pixel accepted on that edge.
    task automatic step(input logic v, input logic [N-1:0] p);
        logic             exp_en;
        logic             exp_fd;
        logic [K*K*N-1:0] exp_win;
        int               exp_sum;
        int               obs_sum;
        exp_en  = 1'b0;
        exp_fd  = 1'b0;
        exp_win = '0;
        exp_sum = 0;
        pix_valid = v;
        pix_in    = p;
        if (v) begin
            img[m_row][m_col] = int'(p);
            if (m_row >= K - 1 && m_col >= K - 1) begin
                exp_en = 1'b1;
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        exp_win[(i*K+j)*N +: N] = N'(img[m_row-K+1+i][m_col-K+1+j]);
                        exp_sum += img[m_row-K+1+i][m_col-K+1+j];
                    end
                end
            end
            exp_fd = (m_row == H - 1) && (m_col == W - 1);
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        check("en_out", 64'(en_out), 64'(exp_en));
        check("frame_done", 64'(frame_done), 64'(exp_fd));
        if (exp_en) begin
            win_cnt++;
            check("data2conv", 64'(data2conv), 64'(exp_win));
            obs_sum = 0;
            for (int i = 0; i < K * K; i++) begin
                obs_sum += int'(data2conv[i*N +: N]);
            end
            check("window_sum", 64'(obs_sum), 64'(exp_sum));
        end
    endtask

    task automatic pattern_pix(input int r, input int c, output logic [N-1:0] p);
        p = N'((5 * r + c) % 16);
    endtask

    // Feeds one full frame, optionally with random idle cycles before pixels.
    task automatic run_frame(input bit use_pattern, input int idle_pct);
        logic [N-1:0] p;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                while (idle_pct > 0 && $urandom_range(99) < idle_pct) begin
                    step(1'b0, N'($urandom));
                end
                if (use_pattern) pattern_pix(r, c, p);
                else             p = N'($urandom);
                step(1'b1, p);
            end
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        pix_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_en_out", 64'(en_out), 64'(0));
            check("rst_frame_done", 64'(frame_done), 64'(0));
            check("rst_data2conv", 64'(data2conv), 64'(0));
        end
        rst   = 1'b0;
        m_row = 0;
        m_col = 0;
    endtask

    // One cycle on the 1x1 instance.
    task automatic step_k1(input logic v, input logic [N-1:0] p);
        logic exp_fd;
        exp_fd = 1'b0;
        pix_valid_k1 = v;
        pix_in_k1    = p;
        if (v) begin
            m1_last = p;
            exp_fd  = (m1_idx == W1 * H1 - 1);
            m1_idx  = (m1_idx == W1 * H1 - 1) ? 0 : m1_idx + 1;
        end
        @(posedge clk);
        #1;
        pix_valid_k1 = 1'b0;
        check("k1_en_out", 64'(en_out_k1), 64'(v));
        check("k1_frame_done", 64'(frame_done_k1), 64'(exp_fd));
        check("k1_data2conv", 64'(data2conv_k1), 64'(m1_last));
        if (v) m1_cnt++;
    endtask

    initial begin
        logic [N-1:0] p;
        pix_in       = '0;
        pix_valid    = 1'b0;
        pix_in_k1    = '0;
        pix_valid_k1 = 1'b0;
        m1_idx       = 0;
        m1_cnt       = 0;
        m1_last      = '0;
        do_reset();

        // Basic frame, continuous valid.
        win_cnt = 0;
        run_frame(1'b1, 0);
        check("basic_window_count", 64'(win_cnt), 64'(9));
        $display("basic frame: windows=%0d", win_cnt);

        // Same frame with about 40% idle cycles.
        win_cnt = 0;
        run_frame(1'b1, 40);
        check("gap_window_count", 64'(win_cnt), 64'(9));
        $display("gapped frame: windows=%0d", win_cnt);

        // Two frames back to back, second one random.
        win_cnt = 0;
        run_frame(1'b1, 0);
        run_frame(1'b0, 0);
        check("b2b_window_count", 64'(win_cnt), 64'(18));
        $display("back-to-back frames: windows=%0d", win_cnt);

        // Reset after pixel (3,1), then a fresh frame.
        win_cnt = 0;
        for (int i = 0; i < 3 * W + 2; i++) begin
            pattern_pix(i / W, i % W, p);
            step(1'b1, p);
        end
        do_reset();
        win_cnt = 0;
        run_frame(1'b1, 0);
        check("post_reset_window_count", 64'(win_cnt), 64'(9));
        $display("frame after mid-frame reset: windows=%0d", win_cnt);

        // 1x1 kernel on a 4x4 image with some idle cycles.
        for (int i = 0; i < W1 * H1; i++) begin
            if ($urandom_range(99) < 30) step_k1(1'b0, N'($urandom));
            step_k1(1'b1, N'($urandom));
        end
        check("k1_window_count", 64'(m1_cnt), 64'(16));
        $display("kernel 1 frame: windows=%0d", m1_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
